// File: rtl/syncfifo_pkg.sv
// Shared helpers for the single-clock flag FIFO: depth derivation, count width
// and threshold legality check.
package syncfifo_pkg;

  function automatic int depth_of(input int asize);
    return 1 << asize;
  endfunction

  // Count holds 0..DEPTH (DEPTH+1 with the output register), so one bit over ASIZE.
  function automatic int cnt_width(input int asize);
    return asize + 1;
  endfunction

  function automatic bit thresh_ok(input int asize, input int afull, input int aempty);
    return (asize >= 1) && (afull >= 1) && (afull <= depth_of(asize)) &&
           (aempty >= 0) && (aempty <= depth_of(asize) - 1);
  endfunction

  typedef struct packed {
    logic wfull;
    logic walmost_full;
    logic rempty;
    logic ralmost_empty;
    logic overflow;
    logic underflow;
  } flags_t;

endpackage

// File: rtl/syncfifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read, no reset.
module syncfifo_mem #(
  parameter int DSIZE = 34,
  parameter int ASIZE = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [2**ASIZE];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/syncfifo_flags.sv
// Single-clock FIFO with registered count, almost flags and sticky error flags.
// Optional SYNCFIFO_OUTREG_EN adds a one-word output register after the memory.
module syncfifo_flags
  import syncfifo_pkg::*;
#(
  parameter int DSIZE         = 34,
  parameter int ASIZE         = 2,
  parameter int AFULL_THRESH  = 3,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  output logic [DSIZE-1:0] rdata,
  input  logic             rinc,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  input  logic             clr_err,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = depth_of(ASIZE);
  localparam int CW    = cnt_width(ASIZE);

  generate
    if (!thresh_ok(ASIZE, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
      $error("syncfifo_flags: illegal ASIZE/AFULL_THRESH/AEMPTY_THRESH");
    end
  endgenerate

  logic [CW-1:0]    wbin, rbin, count_q, count_next;
  logic [DSIZE-1:0] mem_rdata;
  logic             wr_en, rd_en, mem_adv, full_next, empty_next;
  flags_t           flg_q, flg_next;

  assign wr_en      = winc & ~flg_q.wfull;
  assign count_next = count_q + CW'(wr_en) - CW'(rd_en);

`ifdef SYNCFIFO_OUTREG_EN
  // Output register is valid whenever the FIFO reports non-empty.
  logic [DSIZE-1:0] out_q;
  logic [CW-1:0]    mem_cnt, mem_cnt_next;
  logic             out_valid;

  assign out_valid    = ~flg_q.rempty;
  assign mem_cnt      = wbin - rbin;
  assign rd_en        = rinc & out_valid;
  assign mem_adv      = (mem_cnt != '0) & (~out_valid | rd_en);
  assign mem_cnt_next = mem_cnt + CW'(wr_en) - CW'(mem_adv);
  assign full_next    = (mem_cnt_next == CW'(DEPTH));
  assign empty_next   = ~(mem_adv | (out_valid & ~rd_en));

  always_ff @(posedge clk)
    if (mem_adv) out_q <= mem_rdata;

  assign rdata = out_q;
`else
  assign rd_en      = rinc & ~flg_q.rempty;
  assign mem_adv    = rd_en;
  assign full_next  = (count_next == CW'(DEPTH));
  assign empty_next = (count_next == '0);
  assign rdata      = mem_rdata;
`endif

  always_comb begin
    flg_next               = '0;
    flg_next.wfull         = full_next;
    flg_next.rempty        = empty_next;
    flg_next.walmost_full  = (count_next >= CW'(AFULL_THRESH));
    flg_next.ralmost_empty = (count_next <= CW'(AEMPTY_THRESH));
    // Set beats clear when both land in the same cycle.
    flg_next.overflow      = (winc & flg_q.wfull)  | (flg_q.overflow  & ~clr_err);
    flg_next.underflow     = (rinc & flg_q.rempty) | (flg_q.underflow & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbin                <= '0;
      rbin                <= '0;
      count_q             <= '0;
      flg_q               <= '0;
      flg_q.rempty        <= 1'b1;
      flg_q.ralmost_empty <= 1'b1;
    end else begin
      if (wr_en)   wbin <= wbin + 1'b1;
      if (mem_adv) rbin <= rbin + 1'b1;
      count_q <= count_next;
      flg_q   <= flg_next;
    end
  end

  syncfifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wbin[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rbin[ASIZE-1:0]),
    .rdata (mem_rdata)
  );

  assign count         = count_q;
  assign wfull         = flg_q.wfull;
  assign walmost_full  = flg_q.walmost_full;
  assign rempty        = flg_q.rempty;
  assign ralmost_empty = flg_q.ralmost_empty;
  assign overflow      = flg_q.overflow;
  assign underflow     = flg_q.underflow;

endmodule

// File: tb/tb_syncfifo_flags.sv
// Directed, table-driven bench for syncfifo_flags (DSIZE=8, ASIZE=2, AF=3, AE=1).
module tb_syncfifo_flags;

  logic       clk = 1'b0;
  logic       rst_n, winc, rinc, clr_err;
  logic [7:0] wdata, rdata;
  logic       wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  syncfifo_flags #(.DSIZE(8), .ASIZE(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wfull(wfull),
    .walmost_full(walmost_full), .rdata(rdata), .rinc(rinc), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .count(count), .clr_err(clr_err),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, winc, rinc, clr;
    logic [7:0] wdata;
    logic [2:0] e_cnt;
    logic [5:0] e_flg;  // {wfull, walmost_full, rempty, ralmost_empty, overflow, underflow}
    logic       chk_rd;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic w, input logic rd, input logic c,
                              input logic [7:0] wd, input logic [2:0] ec, input logic [5:0] ef,
                              input logic chk, input logic [7:0] er);
    vec_t v;
    v.rst_n = r; v.winc = w; v.rinc = rd; v.clr = c; v.wdata = wd;
    v.e_cnt = ec; v.e_flg = ef; v.chk_rd = chk; v.e_rd = er;
    return v;
  endfunction

  // Drive inputs on the falling edge, let the rising edge act, sample 1 time unit later.
  task automatic step(input logic r, input logic w, input logic rd, input logic c,
                      input logic [7:0] wd);
    @(negedge clk);
    rst_n = r; winc = w; rinc = rd; clr_err = c; wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic [2:0] ec, input logic [5:0] ef,
                             input logic chk, input logic [7:0] er);
    logic [5:0] af;
    af = {wfull, walmost_full, rempty, ralmost_empty, overflow, underflow};
    checks++;
    if (count !== ec || af !== ef) begin
      errors++;
      $display("FAIL %s: count=%0d flags=%b, expected count=%0d flags=%b", name, count, af, ec, ef);
    end
    if (chk) begin
      checks++;
      if (rdata !== er) begin
        errors++;
        $display("FAIL %s rdata: got %h, expected %h", name, rdata, er);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = '0;

`ifdef SYNCFIFO_OUTREG_EN
    vecs.push_back(mk(0,0,0,0,8'h00, 0, 6'b001100, 0, 8'h00));
    vecs.push_back(mk(1,1,0,0,8'hA5, 1, 6'b001100, 0, 8'h00));
    vecs.push_back(mk(1,0,0,0,8'h00, 1, 6'b000100, 1, 8'hA5));
    vecs.push_back(mk(1,1,0,0,8'hB0, 2, 6'b000000, 1, 8'hA5));
    vecs.push_back(mk(1,1,0,0,8'hB1, 3, 6'b010000, 1, 8'hA5));
    vecs.push_back(mk(1,1,0,0,8'hB2, 4, 6'b010000, 1, 8'hA5));
    vecs.push_back(mk(1,1,0,0,8'hB3, 5, 6'b110000, 1, 8'hA5));
    vecs.push_back(mk(1,0,1,0,8'h00, 4, 6'b010000, 1, 8'hB0));
    vecs.push_back(mk(0,1,1,1,8'hCC, 0, 6'b001100, 0, 8'h00));
`else
    vecs.push_back(mk(0,0,0,0,8'h00, 0, 6'b001100, 0, 8'h00)); // reset
    vecs.push_back(mk(1,0,0,0,8'h00, 0, 6'b001100, 0, 8'h00)); // idle
    vecs.push_back(mk(1,1,0,0,8'h11, 1, 6'b000100, 1, 8'h11));
    vecs.push_back(mk(1,1,0,0,8'h22, 2, 6'b000000, 1, 8'h11));
    vecs.push_back(mk(1,1,0,0,8'h33, 3, 6'b010000, 1, 8'h11));
    vecs.push_back(mk(1,1,0,0,8'h44, 4, 6'b110000, 1, 8'h11));
    vecs.push_back(mk(1,1,0,0,8'h55, 4, 6'b110010, 1, 8'h11)); // write while full
    vecs.push_back(mk(1,0,1,0,8'h00, 3, 6'b010010, 1, 8'h22));
    vecs.push_back(mk(1,0,1,0,8'h00, 2, 6'b000010, 1, 8'h33));
    vecs.push_back(mk(1,0,1,0,8'h00, 1, 6'b000110, 1, 8'h44));
    vecs.push_back(mk(1,0,1,0,8'h00, 0, 6'b001110, 0, 8'h00));
    vecs.push_back(mk(1,0,1,1,8'h00, 0, 6'b001101, 0, 8'h00)); // clear ovf, set unf wins
    vecs.push_back(mk(1,0,0,1,8'h00, 0, 6'b001100, 0, 8'h00));
    vecs.push_back(mk(1,1,0,0,8'h11, 1, 6'b000100, 1, 8'h11));
    vecs.push_back(mk(1,1,0,0,8'h22, 2, 6'b000000, 1, 8'h11));
    vecs.push_back(mk(1,1,0,0,8'h33, 3, 6'b010000, 1, 8'h11));
    vecs.push_back(mk(1,1,0,0,8'h44, 4, 6'b110000, 1, 8'h11));
    vecs.push_back(mk(1,1,1,0,8'h66, 3, 6'b010010, 1, 8'h22)); // full: read wins
    vecs.push_back(mk(1,0,1,0,8'h00, 2, 6'b000010, 1, 8'h33));
    vecs.push_back(mk(1,0,1,0,8'h00, 1, 6'b000110, 1, 8'h44));
    vecs.push_back(mk(1,0,1,0,8'h00, 0, 6'b001110, 0, 8'h00));
    vecs.push_back(mk(1,1,1,0,8'h77, 1, 6'b000111, 1, 8'h77)); // empty: write wins
    vecs.push_back(mk(1,0,0,1,8'h00, 1, 6'b000100, 1, 8'h77));
    vecs.push_back(mk(1,1,0,0,8'h88, 2, 6'b000000, 1, 8'h77));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].winc, vecs[i].rinc, vecs[i].clr, vecs[i].wdata);
      check_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_flg, vecs[i].chk_rd, vecs[i].e_rd);
    end

`ifndef SYNCFIFO_OUTREG_EN
    // Ten write/read pairs at count=2 carry both pointers across their wrap.
    // Contents start as [77,88]; each pair appends A0+i and pops the head.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] exp_head;
      exp_head = (i == 0) ? 8'h88 : 8'(8'hA0 + i - 1);
      step(1, 1, 1, 0, 8'(8'hA0 + i));
      check_state($sformatf("wrap%0d", i), 3'd2, 6'b000000, 1, exp_head);
    end

    // Reset mid-stream overrides a concurrent write.
    step(0, 1, 1, 1, 8'hEE);
    check_state("midrst", 3'd0, 6'b001100, 0, 8'h00);
    step(1, 1, 0, 0, 8'h99);
    check_state("post_rst_wr", 3'd1, 6'b000100, 1, 8'h99);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
